alu_op_sequencer: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 37 +++
 rtl/alu_op_sequencer_if.sv | 32 +++
 rtl/pb_edge.sv | 32 +++
 rtl/alu_op_sequencer.sv | 116 +++++++++++
 tb/tb_alu_op_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared definitions for the LCD demo board ALU datapath: the 3-bit
// sequencer state encodings (also shown on the LCD through state_o) and
// the 4-bit ALU opcode set used by both the ALU and alu_op_sequencer.
package alu_ctrl_pkg;

  // Sequencer states. Encodings 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  // ALU opcodes; the ALU decodes alu_sel against these values.
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_ROL   = 4'd8,
    OP_ROR   = 4'd9,
    OP_INC   = 4'd10,
    OP_DEC   = 4'd11,
    OP_PASSA = 4'd12,
    OP_PASSB = 4'd13,
    OP_LT    = 4'd14,
    OP_EQ    = 4'd15
  } opcode_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Bundles the user inputs, ALU operand/result bus and display handshake
// of alu_op_sequencer.
//   master : the sequencer (drives operands, captured result, disp_req,
//            busy, err, state_o; reads btn, sw, ALU outputs, disp_ack)
//   slave  : the surroundings (debouncer, ALU, display writer)
interface alu_op_sequencer_if;
  logic       btn;
  logic [7:0] sw;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] result;
  logic       carry;
  logic       disp_req;
  logic       disp_ack;
  logic       busy;
  logic       err;
  logic [2:0] state_o;

  modport master (
    input  btn, sw, alu_result, alu_carry, disp_ack,
    output alu_a, alu_b, alu_sel, result, carry, disp_req, busy, err, state_o
  );

  modport slave (
    output btn, sw, alu_result, alu_carry, disp_ack,
    input  alu_a, alu_b, alu_sel, result, carry, disp_req, busy, err, state_o
  );
endinterface

// File: rtl/pb_edge.sv
// pb_edge
// Rising-edge detector for a debounced push-button level.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   btn   : debounced button level
//   press : single-cycle pulse on each rising edge of btn
module pb_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic btn_q;
  logic armed;

  // btn_q follows the button; armed stays low for the first clock after
  // reset so that a button held through reset release is taken as the
  // baseline level rather than as a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      btn_q <= btn;
      armed <= 1'b1;
    end
  end

  assign press = btn & ~btn_q & armed;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Walks the user through entering operand A, operand B and the opcode with
// one push-button, drives the ALU with registered operands, captures the
// result after a settle delay and requests an LCD refresh with a
// four-phase req/ack handshake guarded by a timeout.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : alu_op_sequencer_if.master (btn/sw in, ALU bus, display
//         handshake, busy/err/state_o status)
// Parameters:
//   SETTLE_CYCLES : edges from EXEC entry to result capture (1..15)
//   ACK_TIMEOUT   : edges from SHOW entry to handshake abort (1..65535)
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ACK_TIMEOUT   = 1023
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.master bus
);
  import alu_ctrl_pkg::*;

  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  logic        press;
  logic [3:0]  settle_cnt;
  logic [15:0] hs_cnt;

  pb_edge u_pb_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn),
    .press (press)
  );

  // Main sequencer. All outputs are registered here; busy is updated on
  // the same edge that enters or leaves EXEC/SHOW/RELEASE. The handshake
  // counter counts edges since SHOW entry and aborts on the ACK_TIMEOUT-th
  // one, which takes priority over an ack seen on that same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      bus.alu_a    <= 8'd0;
      bus.alu_b    <= 8'd0;
      bus.alu_sel  <= OP_ADD;
      bus.result   <= 8'd0;
      bus.carry    <= 1'b0;
      bus.disp_req <= 1'b0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
      settle_cnt   <= 4'd0;
      hs_cnt       <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press) begin
            bus.alu_a <= bus.sw;
            bus.err   <= 1'b0;
            state     <= ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (press) begin
            bus.alu_b <= bus.sw;
            state     <= ST_GET_OP;
          end
        end
        ST_GET_OP: begin
          if (press) begin
            bus.alu_sel <= bus.sw[3:0];
            settle_cnt  <= SETTLE_LOAD;
            bus.busy    <= 1'b1;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (settle_cnt == 4'd0) begin
            bus.result   <= bus.alu_result;
            bus.carry    <= bus.alu_carry;
            bus.disp_req <= 1'b1;
            hs_cnt       <= 16'd0;
            state        <= ST_SHOW;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_SHOW, ST_RELEASE: begin
          if (hs_cnt == TIMEOUT_LAST) begin
            bus.err      <= 1'b1;
            bus.disp_req <= 1'b0;
            bus.busy     <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            hs_cnt <= hs_cnt + 16'd1;
            if (state == ST_SHOW && bus.disp_ack) begin
              bus.disp_req <= 1'b0;
              state        <= ST_RELEASE;
            end else if (state == ST_RELEASE && !bus.disp_ack) begin
              bus.busy <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.state_o = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer: a behavioural ALU, a display
// writer responder, a cycle reference model of the operator-visible
// behaviour, directed scenarios with literal expectations and a
// randomized loop.
module tb_alu_op_sequencer;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;

  alu_op_sequencer_if ifc ();

  alu_op_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .ACK_TIMEOUT   (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural ALU: {carry, result} for each opcode.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] sel);
    logic [8:0] r;
    case (sel)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} - {1'b0, b};
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {1'b0, ~a};
      4'd6:    r = {a, 1'b0};
      4'd7:    r = {a[0], 1'b0, a[7:1]};
      4'd8:    r = {a[7], a[6:0], a[7]};
      4'd9:    r = {a[0], a[0], a[7:1]};
      4'd10:   r = {1'b0, a} + 9'd1;
      4'd11:   r = {1'b0, a} - 9'd1;
      4'd12:   r = {1'b0, a};
      4'd13:   r = {1'b0, b};
      4'd14:   r = {8'd0, a < b};
      default: r = {8'd0, a == b};
    endcase
    return r;
  endfunction

  logic [8:0] alu_out;
  assign alu_out        = alu_fn(ifc.alu_a, ifc.alu_b, ifc.alu_sel);
  assign ifc.alu_result = alu_out[7:0];
  assign ifc.alu_carry  = alu_out[8];

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Display writer: raises ack ack_delay cycles after seeing req, drops it
  // rel_delay cycles after req falls; never_ack models a dead writer and
  // ack_hold forces ack high for a number of cycles regardless of req.
  int ack_delay = 0, rel_delay = 0, ack_hold = 0, r_cnt = 0;
  bit never_ack = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      ifc.disp_ack = 1'b0;
      r_cnt = 0;
      ack_hold = 0;
    end else if (ack_hold > 0) begin
      ifc.disp_ack = 1'b1;
      ack_hold--;
    end else if (never_ack) begin
      ifc.disp_ack = 1'b0;
    end else if (!ifc.disp_ack) begin
      if (ifc.disp_req) begin
        if (r_cnt >= ack_delay) begin
          ifc.disp_ack = 1'b1;
          r_cnt = 0;
        end else r_cnt++;
      end else r_cnt = 0;
    end else if (!ifc.disp_req) begin
      if (r_cnt >= rel_delay) begin
        ifc.disp_ack = 1'b0;
        r_cnt = 0;
      end else r_cnt++;
    end
  end

  // Reference model: phase 0..5 as shown on the LCD, edges remaining until
  // capture, and edges elapsed in the handshake.
  int         m_phase = 0, m_wait = 0, m_hs = 0;
  logic [7:0] m_a = 0, m_b = 0, m_res = 0;
  logic [3:0] m_sel = 0;
  logic       m_carry = 0, m_req = 0, m_err = 0, m_prev = 0, m_seen = 0;
  logic [8:0] m_alu;

  always @(posedge clk or negedge rst) begin : model
    bit press;
    if (!rst) begin
      m_phase = 0; m_wait = 0; m_hs = 0;
      m_a = 0; m_b = 0; m_sel = 0; m_res = 0;
      m_carry = 0; m_req = 0; m_err = 0; m_prev = 0; m_seen = 0;
    end else begin
      press  = m_seen && ifc.btn && !m_prev;
      m_prev = ifc.btn;
      m_seen = 1'b1;
      if (m_phase == 0 && press) begin
        m_a = ifc.sw; m_err = 0; m_phase = 1;
      end else if (m_phase == 1 && press) begin
        m_b = ifc.sw; m_phase = 2;
      end else if (m_phase == 2 && press) begin
        m_sel = ifc.sw[3:0]; m_wait = SETTLE; m_phase = 3;
      end else if (m_phase == 3) begin
        m_wait--;
        if (m_wait == 0) begin
          m_alu = alu_fn(m_a, m_b, m_sel);
          m_res = m_alu[7:0]; m_carry = m_alu[8];
          m_req = 1; m_hs = 0; m_phase = 4;
        end
      end else if (m_phase >= 4) begin
        m_hs++;
        if (m_hs == TIMEOUT) begin
          m_err = 1; m_req = 0; m_phase = 0;
        end else if (m_phase == 4 && ifc.disp_ack) begin
          m_req = 0; m_phase = 5;
        end else if (m_phase == 5 && !ifc.disp_ack) begin
          m_phase = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    checkOutput("cyc_state",  16'(ifc.state_o),  16'(m_phase));
    checkOutput("cyc_alu_a",  16'(ifc.alu_a),    16'(m_a));
    checkOutput("cyc_alu_b",  16'(ifc.alu_b),    16'(m_b));
    checkOutput("cyc_sel",    16'(ifc.alu_sel),  16'(m_sel));
    checkOutput("cyc_result", 16'(ifc.result),   16'(m_res));
    checkOutput("cyc_carry",  16'(ifc.carry),    16'(m_carry));
    checkOutput("cyc_req",    16'(ifc.disp_req), 16'(m_req));
    checkOutput("cyc_err",    16'(ifc.err),      16'(m_err));
    checkOutput("cyc_busy",   16'(ifc.busy),     16'(m_phase >= 3));
  end

  // Observation counters for literal timing checks.
  int exec_cnt = 0, req_cnt = 0, show_cnt = 0, rel_cnt = 0;
  always @(negedge clk) begin
    if (ifc.state_o == 3'd3) exec_cnt++;
    if (ifc.disp_req) req_cnt++;
    if (ifc.state_o == 3'd4 || ifc.state_o == 3'd5) show_cnt++;
    if (ifc.state_o == 3'd5) rel_cnt++;
  end

  task automatic clearCounters();
    exec_cnt = 0; req_cnt = 0; show_cnt = 0; rel_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pressBtn(input logic [7:0] val, input int hold);
    ifc.sw  = val;
    ifc.btn = 1'b1;
    repeat (hold) @(negedge clk);
    ifc.btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (ifc.state_o != 3'd0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 16'(ifc.state_o), 16'd0);
  endtask

  // One complete entry/execute/display transaction.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] sel, input int ad, input int rd,
                               input int hold, input int gap, input bit stray_exec,
                               input bit stray_show, input bit pre_high);
    int n;
    ack_delay = ad;
    rel_delay = rd;
    pressBtn(a, hold);
    tick(gap);
    pressBtn(b, hold);
    tick(gap);
    pressBtn({4'($urandom), sel}, 1);
    if (pre_high) ack_hold = 8;
    if (stray_exec) pressBtn(8'($urandom), 1);
    if (stray_show) begin
      n = 0;
      while (!ifc.disp_req && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput("req_seen", 16'(ifc.disp_req), 16'd1);
      pressBtn(8'($urandom), 1);
    end
    waitIdle("op_idle");
  endtask

  initial begin
    ifc.btn = 1'b0;
    ifc.sw  = 8'd0;
    rst     = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    checkOutput("rst_state",  16'(ifc.state_o), 16'd0);
    checkOutput("rst_alu_a",  16'(ifc.alu_a),   16'd0);
    checkOutput("rst_result", 16'(ifc.result),  16'd0);
    checkOutput("rst_err",    16'(ifc.err),     16'd0);

    // 5 + 3, ack three cycles after req
    clearCounters();
    applyStimulus(8'd5, 8'd3, 4'd0, 3, 1, 1, 1, 0, 0, 0);
    checkOutput("add_result", 16'(ifc.result), 16'd8);
    checkOutput("add_carry",  16'(ifc.carry),  16'd0);
    checkOutput("add_reqw",   16'(req_cnt),    16'd4);
    checkOutput("add_exec",   16'(exec_cnt),   16'(SETTLE));
    checkOutput("add_a",      16'(ifc.alu_a),  16'd5);
    checkOutput("add_b",      16'(ifc.alu_b),  16'd3);

    // 200 + 100 overflows
    clearCounters();
    applyStimulus(8'd200, 8'd100, 4'd0, 1, 0, 2, 0, 0, 0, 0);
    checkOutput("ovf_result", 16'(ifc.result), 16'd44);
    checkOutput("ovf_carry",  16'(ifc.carry),  16'd1);
    checkOutput("ovf_exec",   16'(exec_cnt),   16'd4);

    // presses during EXEC and SHOW are ignored
    clearCounters();
    applyStimulus(8'd17, 8'd9, 4'd1, 4, 2, 1, 0, 1, 1, 0);
    checkOutput("stray_result", 16'(ifc.result),  16'd8);
    checkOutput("stray_a",      16'(ifc.alu_a),   16'd17);
    checkOutput("stray_b",      16'(ifc.alu_b),   16'd9);
    checkOutput("stray_sel",    16'(ifc.alu_sel), 16'd1);
    checkOutput("stray_exec",   16'(exec_cnt),    16'd4);

    // handshake timeout, then err clears on the next A entry
    never_ack = 1'b1;
    clearCounters();
    applyStimulus(8'd1, 8'd2, 4'd0, 0, 0, 1, 0, 0, 0, 0);
    never_ack = 1'b0;
    checkOutput("to_cycles", 16'(show_cnt),     16'(TIMEOUT));
    checkOutput("to_err",    16'(ifc.err),      16'd1);
    checkOutput("to_req",    16'(ifc.disp_req), 16'd0);
    checkOutput("to_result", 16'(ifc.result),   16'd3);
    pressBtn(8'd77, 1);
    checkOutput("to_clr_err",   16'(ifc.err),     16'd0);
    checkOutput("to_clr_state", 16'(ifc.state_o), 16'd1);
    checkOutput("to_clr_a",     16'(ifc.alu_a),   16'd77);
    pressBtn(8'd1, 1);
    pressBtn(8'd0, 1);
    waitIdle("to_idle");

    // ack already high at SHOW entry
    clearCounters();
    applyStimulus(8'd10, 8'd20, 4'd3, 0, 0, 1, 0, 0, 0, 1);
    checkOutput("pre_reqw",   16'(req_cnt),      16'd1);
    checkOutput("pre_rel",    16'(rel_cnt >= 2), 16'd1);
    checkOutput("pre_result", 16'(ifc.result),   16'd30);

    // reset in SHOW with btn held high
    never_ack = 1'b1;
    pressBtn(8'd10, 1);
    pressBtn(8'd20, 1);
    pressBtn(8'd2, 1);
    begin
      int n;
      n = 0;
      while (ifc.state_o != 3'd4 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("rs_show", 16'(ifc.state_o), 16'd4);
    ifc.btn = 1'b1;
    #3 rst = 1'b0;
    #2;
    checkOutput("rs_state",  16'(ifc.state_o),  16'd0);
    checkOutput("rs_a",      16'(ifc.alu_a),    16'd0);
    checkOutput("rs_b",      16'(ifc.alu_b),    16'd0);
    checkOutput("rs_sel",    16'(ifc.alu_sel),  16'd0);
    checkOutput("rs_result", 16'(ifc.result),   16'd0);
    checkOutput("rs_req",    16'(ifc.disp_req), 16'd0);
    checkOutput("rs_busy",   16'(ifc.busy),     16'd0);
    tick(2);
    rst = 1'b1;
    never_ack = 1'b0;
    tick(5);
    checkOutput("rs_hold_state", 16'(ifc.state_o), 16'd0);
    checkOutput("rs_hold_a",     16'(ifc.alu_a),   16'd0);
    ifc.btn = 1'b0;
    tick(1);
    pressBtn(8'd99, 1);
    checkOutput("rs_press_state", 16'(ifc.state_o), 16'd1);
    checkOutput("rs_press_a",     16'(ifc.alu_a),   16'd99);
    pressBtn(8'd5, 1);
    pressBtn(8'd0, 1);
    waitIdle("rs_idle");

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      bit pre, ss, se;
      pre = ($urandom_range(0, 7) == 0);
      se  = 1'($urandom);
      ss  = pre ? 1'b0 : 1'($urandom);
      never_ack = ($urandom_range(0, 7) == 0);
      applyStimulus(8'($urandom), 8'($urandom), 4'($urandom),
                    $urandom_range(0, 5), $urandom_range(0, 4),
                    $urandom_range(1, 3), $urandom_range(0, 3), se, ss, pre);
      never_ack = 1'b0;
      tick($urandom_range(0, 3));
    end

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
